chroma_upsampler_stream: RTL and testbench

// - Streaming successor to the fixed 8x8 chroma supersampler. Sits between chroma IDCT output and colour conversion.
// - Accepts one DW-bit signed 8x8 chroma block per valid/ready handshake.
// - Emits 1, 2 or 4 upsampled 8x8 blocks in raster order, one per output handshake, by nearest-neighbour replication.
// - Subsampling mode is selectable per block: 4:4:4, 4:2:2 or 4:2:0.

---
 rtl/chroma_upsampler_stream.sv | 166 ++++++++++++++++
 tb/tb_chroma_upsampler_stream.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/chroma_upsampler_stream.sv
// rtl/chroma_upsampler_stream.sv - streaming 8x8 chroma upsampler (4:4:4/4:2:2/4:2:0), option macro UPSAMPLE_PINGPONG_EN
module chroma_upsampler_stream #(
    parameter int DW   = 9,
    parameter int CH_W = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [1:0]             mode,
    input  logic [CH_W-1:0]        ch_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0][7:0][DW-1:0] in_block,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0][7:0][DW-1:0] out_block,
    output logic [1:0]             out_idx,
    output logic                   out_last,
    output logic [CH_W-1:0]        out_ch
);
    typedef enum logic {IDLE, EMIT} state_t;
    typedef logic [7:0][7:0][DW-1:0] blk_t;

    state_t          state, state_nx;
    blk_t            cur_blk;
    logic [1:0]      cur_lim;
    logic            fire_out, fire_last, accept;
    logic [1:0]      in_lim, nxt_idx;
    logic            load_en;
    blk_t            load_blk;
    logic [1:0]      load_lim;
    logic [CH_W-1:0] load_ch;

`ifdef UPSAMPLE_PINGPONG_EN
    logic            pend_valid;
    blk_t            pend_blk;
    logic [1:0]      pend_lim;
    logic [CH_W-1:0] pend_ch;
    logic            load_pend, store_pend;
`endif

    // Last sub-block index for a mode: 0 (4:4:4), 1 (4:2:2), 3 (4:2:0)
    function automatic logic [1:0] lim_of(input logic [1:0] m);
        case (m)
            2'b01:   lim_of = 2'd1;
            2'b10:   lim_of = 2'd3;
            default: lim_of = 2'd0;
        endcase
    endfunction

    function automatic blk_t upsample(input blk_t blk, input logic [1:0] lim, input logic [1:0] idx);
        blk_t r;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                case (lim)
                    2'd1:    r[i][j] = blk[i[2:0]][{idx[0], j[2:1]}];
                    2'd3:    r[i][j] = blk[{idx[1], i[2:1]}][{idx[0], j[2:1]}];
                    default: r[i][j] = blk[i[2:0]][j[2:0]];
                endcase
            end
        end
        return r;
    endfunction

    always_comb begin
        fire_out  = out_valid && out_ready;
        fire_last = fire_out && out_last;
        in_lim    = lim_of(mode);
        nxt_idx   = out_idx + 2'd1;
        in_ready  = 1'b0;
        state_nx  = state;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = EMIT;
            end
            EMIT: begin
`ifdef UPSAMPLE_PINGPONG_EN
                // The pending slot frees on the last output, so it may refill that same edge
                in_ready = !pend_valid || fire_last;
                if (fire_last && !pend_valid && !in_valid) state_nx = IDLE;
`else
                if (fire_last) state_nx = IDLE;
`endif
            end
            default: state_nx = IDLE;
        endcase
        in_ready = in_ready && reset_n;
        accept   = in_valid && in_ready;
    end

    always_comb begin
        load_blk = in_block;
        load_lim = in_lim;
        load_ch  = ch_in;
        load_en  = (state == IDLE) && accept;
`ifdef UPSAMPLE_PINGPONG_EN
        load_pend  = 1'b0;
        store_pend = 1'b0;
        if (state == EMIT) begin
            if (fire_last && pend_valid) begin
                load_pend  = 1'b1;
                load_en    = 1'b1;
                load_blk   = pend_blk;
                load_lim   = pend_lim;
                load_ch    = pend_ch;
                store_pend = accept;
            end else if (fire_last && accept) begin
                load_en = 1'b1;
            end else begin
                store_pend = accept;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_idx   <= 2'd0;
            out_last  <= 1'b0;
            out_ch    <= '0;
            out_block <= '0;
            cur_blk   <= '0;
            cur_lim   <= 2'd0;
`ifdef UPSAMPLE_PINGPONG_EN
            pend_valid <= 1'b0;
            pend_blk   <= '0;
            pend_lim   <= 2'd0;
            pend_ch    <= '0;
`endif
        end else begin
            if (load_en) begin
                cur_blk   <= load_blk;
                cur_lim   <= load_lim;
                out_block <= upsample(load_blk, load_lim, 2'd0);
                out_idx   <= 2'd0;
                out_last  <= (load_lim == 2'd0);
                out_ch    <= load_ch;
                out_valid <= 1'b1;
            end else if (fire_out) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                end else begin
                    out_idx   <= nxt_idx;
                    out_block <= upsample(cur_blk, cur_lim, nxt_idx);
                    out_last  <= (nxt_idx == cur_lim);
                end
            end
`ifdef UPSAMPLE_PINGPONG_EN
            if (store_pend) begin
                pend_valid <= 1'b1;
                pend_blk   <= in_block;
                pend_lim   <= in_lim;
                pend_ch    <= ch_in;
            end else if (load_pend) begin
                pend_valid <= 1'b0;
            end
`endif
        end
    end
endmodule

// File: tb/tb_chroma_upsampler_stream.sv
// tb/tb_chroma_upsampler_stream.sv - table-driven bench for chroma_upsampler_stream
module tb_chroma_upsampler_stream;
    localparam int DW   = 9;
    localparam int CH_W = 2;
    typedef logic [7:0][7:0][DW-1:0] blk_t;
    typedef struct {
        logic [1:0]      mode;
        logic [CH_W-1:0] ch;
        int              pat;
        int              n_exp;
        int              ci;
        int              cr;
        int              cc;
        int              cval;
    } vec_t;

    logic            clock = 1'b0;
    logic            reset_n;
    logic [1:0]      mode;
    logic [CH_W-1:0] ch_in;
    logic            in_valid;
    logic            in_ready;
    blk_t            in_block;
    logic            out_valid;
    logic            out_ready;
    blk_t            out_block;
    logic [1:0]      out_idx;
    logic            out_last;
    logic [CH_W-1:0] out_ch;

    always #5 clock = ~clock;

    chroma_upsampler_stream #(.DW(DW), .CH_W(CH_W)) dut (
        .clock(clock), .reset_n(reset_n), .mode(mode), .ch_in(ch_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_block(in_block),
        .out_valid(out_valid), .out_ready(out_ready), .out_block(out_block),
        .out_idx(out_idx), .out_last(out_last), .out_ch(out_ch)
    );

    int              n_cmp = 0;
    int              n_bad = 0;
    blk_t            cap_blk [8];
    logic [1:0]      cap_idx [8];
    logic            cap_last[8];
    logic [CH_W-1:0] cap_ch  [8];
    int              n_cap;
    vec_t            vecs[10];

    function automatic logic [DW-1:0] pat_val(input int pat, input int r, input int c);
        int v;
        case (pat)
            0:       v = 8*r + c + 1;
            1:       v = -(8*r + c);
            2:       v = ((r + c) % 2 == 0) ? -256 : 255;
            default: v = 37*r + 5*c - 100;
        endcase
        return v[DW-1:0];
    endfunction

    function automatic blk_t make_block(input int pat);
        blk_t b;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                b[r][c] = pat_val(pat, r, c);
        return b;
    endfunction

    function automatic blk_t exp_sub(input int pat, input logic [1:0] m, input int idx);
        blk_t b;
        int sr, sc;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                case (m)
                    2'b01:   begin sr = r;                   sc = 4*idx + c/2;       end
                    2'b10:   begin sr = 4*(idx/2) + r/2;     sc = 4*(idx%2) + c/2;   end
                    default: begin sr = r;                   sc = c;                 end
                endcase
                b[r][c] = pat_val(pat, sr, sc);
            end
        end
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, $signed(got), $signed(exp));
        end
    endtask

    task automatic check_blk(input string name, input blk_t got, input blk_t exp);
        bit shown;
        n_cmp++;
        shown = 0;
        if (got !== exp) begin
            n_bad++;
            for (int r = 0; r < 8; r++)
                for (int c = 0; c < 8; c++)
                    if (!shown && got[r][c] !== exp[r][c]) begin
                        shown = 1;
                        $display("FAIL %s: [%0d][%0d] got %0d expected %0d", name, r, c,
                                 $signed(got[r][c]), $signed(exp[r][c]));
                    end
        end
    endtask

    // Send one block, collect its sub-blocks, check them against the model
    task automatic run_block(input logic [1:0] m, input logic [CH_W-1:0] ch, input int pat,
                             input int n_exp, input bit stall);
        bit         acc, done, prev_stall;
        blk_t       prev_blk;
        logic [1:0] prev_idx;
        acc = 0; done = 0; prev_stall = 0; prev_blk = '0; prev_idx = 2'd0;
        n_cap = 0;
        @(negedge clock);
        mode = m; ch_in = ch; in_block = make_block(pat); in_valid = 1'b1;
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            out_ready = stall ? (cyc % 3 == 2) : 1'b1;
            #1;
            if (prev_stall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_idx", 32'(out_idx), 32'(prev_idx));
                check_blk("stall_block", out_block, prev_blk);
            end
            prev_stall = out_valid && !out_ready;
            prev_blk   = out_block;
            prev_idx   = out_idx;
            if (in_valid && in_ready) acc = 1;
            if (out_valid && out_ready && n_cap < 8) begin
                cap_blk[n_cap]  = out_block;
                cap_idx[n_cap]  = out_idx;
                cap_last[n_cap] = out_last;
                cap_ch[n_cap]   = out_ch;
                n_cap++;
                if (out_last) done = 1;
            end
            @(negedge clock);
            if (acc) begin
                in_valid = 1'b0;
                mode     = m ^ 2'b11;
                ch_in    = ~ch;
                in_block = make_block(3);
            end
        end
        check("block_done", 32'(done), 32'd1);
        check("n_out", n_cap, n_exp);
        for (int k = 0; k < n_exp && k < n_cap; k++) begin
            check("out_idx", 32'(cap_idx[k]), k);
            check("out_last", 32'(cap_last[k]), 32'(k == n_exp - 1));
            check("out_ch", 32'(cap_ch[k]), 32'(ch));
            check_blk("out_block", cap_blk[k], exp_sub(pat, m, k));
        end
    endtask

    initial begin
        int         first, lastc, n_acc, cv, seen;
        bit         found;
        logic [DW-1:0] ev;

        vecs[0] = '{2'b10, 2'b01, 0, 4, 0, 0, 0, 1};
        vecs[1] = '{2'b10, 2'b01, 0, 4, 0, 1, 1, 1};
        vecs[2] = '{2'b10, 2'b01, 0, 4, 3, 0, 0, 37};
        vecs[3] = '{2'b10, 2'b01, 0, 4, 3, 7, 7, 64};
        vecs[4] = '{2'b01, 2'b10, 1, 2, 1, 2, 0, -20};
        vecs[5] = '{2'b01, 2'b10, 1, 2, 1, 2, 7, -23};
        vecs[6] = '{2'b00, 2'b01, 0, 1, 0, 3, 5, 30};
        vecs[7] = '{2'b11, 2'b10, 1, 1, 0, 7, 7, -63};
        vecs[8] = '{2'b01, 2'b01, 2, 2, 0, 0, 0, -256};
        vecs[9] = '{2'b10, 2'b10, 2, 4, 1, 0, 2, 255};

        // Reset held with a block already offered
        reset_n = 1'b0; in_valid = 1'b1; mode = 2'b10; ch_in = 2'b01;
        in_block = make_block(0); out_ready = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_ch", 32'(out_ch), 32'd0);
        check_blk("rst_out_block", out_block, '0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("rel_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock);
        in_valid = 1'b0;
        #1;
        check("first_out_valid", 32'(out_valid), 32'd1);
        check("first_out_idx", 32'(out_idx), 32'd0);
        check("first_out_ch", 32'(out_ch), 32'd1);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && out_valid; i++) begin
            @(negedge clock);
            #1;
        end
        check("drain_done", 32'(out_valid), 32'd0);

        for (int v = 0; v < 10; v++) begin
            run_block(vecs[v].mode, vecs[v].ch, vecs[v].pat, vecs[v].n_exp, 1'b0);
            cv = vecs[v].cval;
            ev = cv[DW-1:0];
            check($sformatf("vec%0d_sample", v), 32'(cap_blk[vecs[v].ci][vecs[v].cr][vecs[v].cc]), 32'(ev));
        end

        // Backpressure: out_ready pattern 0,0,1
        run_block(2'b10, 2'b01, 1, 4, 1'b1);

        // Back-to-back 4:2:0 blocks with in_valid held high
        @(negedge clock);
        mode = 2'b10; ch_in = 2'b10; in_block = make_block(0); in_valid = 1'b1; out_ready = 1'b1;
        n_cap = 0; n_acc = 0; first = 0; lastc = 0;
        for (int cyc = 0; cyc < 60 && n_cap < 8; cyc++) begin
            #1;
            if (in_valid && in_ready) n_acc++;
            if (out_valid && out_ready) begin
                if (n_cap == 0) first = cyc;
                lastc = cyc;
                cap_blk[n_cap] = out_block;
                cap_idx[n_cap] = out_idx;
                cap_last[n_cap] = out_last;
                n_cap++;
            end
            @(negedge clock);
            if (n_acc == 1) in_block = make_block(1);
            else if (n_acc >= 2) in_block = make_block(3);
        end
        check("b2b_n_out", n_cap, 8);
`ifdef UPSAMPLE_PINGPONG_EN
        check("b2b_span", lastc - first, 7);
`else
        check("b2b_span", lastc - first, 8);
`endif
        for (int k = 0; k < 8 && k < n_cap; k++) begin
            check("b2b_idx", 32'(cap_idx[k]), k % 4);
            check("b2b_last", 32'(cap_last[k]), 32'(k % 4 == 3));
        end
        check_blk("b2b_a0", cap_blk[0], exp_sub(0, 2'b10, 0));
        check_blk("b2b_a3", cap_blk[3], exp_sub(0, 2'b10, 3));
        check_blk("b2b_b0", cap_blk[4], exp_sub(1, 2'b10, 0));
        check_blk("b2b_b3", cap_blk[7], exp_sub(1, 2'b10, 3));

        // Reset asserted while the next block shows idx 1
        found = 0;
        for (int cyc = 0; cyc < 20 && !found; cyc++) begin
            #1;
            if (out_valid && out_idx == 2'd1) found = 1;
            else @(negedge clock);
        end
        check("rst_point_found", 32'(found), 32'd1);
        reset_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_out_idx", 32'(out_idx), 32'd0);
        @(negedge clock);
        in_valid = 1'b0;
        reset_n = 1'b1;
        seen = 0;
        for (int cyc = 0; cyc < 6; cyc++) begin
            #1;
            if (out_valid) seen++;
            @(negedge clock);
        end
        check("no_partial_output", seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
